pixel_buffer_responder: RTL and testbench

//  Avalon-MM responder serving the VGA pixel DMA master's 16-bit pixel reads from an on-chip RGB565 frame buffer.

---
 rtl/pixel_buf_pkg.sv | 17 +
 rtl/pixel_buf_ram.sv | 25 ++
 rtl/pixel_buffer_responder.sv | 155 +++++++++++++++
 tb/tb_pixel_buffer_responder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_buf_pkg.sv
// Shared types and default geometry for the RGB565 pixel frame buffer.
package pixel_buf_pkg;

  localparam int PIX_W     = 16;
  localparam int H_RES_DEF = 320;
  localparam int V_RES_DEF = 240;
  localparam int DEPTH_DEF = H_RES_DEF * V_RES_DEF;
  localparam int IDX_W_DEF = $clog2(DEPTH_DEF);

  typedef enum logic {
    CLR_IDLE,
    CLR_RUN
  } clr_state_t;

  localparam logic [PIX_W-1:0] PIX_BLACK = 16'h0000;

endpackage

// File: rtl/pixel_buf_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read and a write to the same word in one cycle return the old word.
module pixel_buf_ram #(
  parameter int DEPTH = 76800,
  parameter int AW    = 17,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Both ports in one process so the read samples the pre-write word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pixel_buffer_responder.sv
// Avalon-MM pixel read responder with a draw write port and an optional
// clear engine (enabled by defining PIXEL_BUF_CLEAR_EN).
module pixel_buffer_responder
  import pixel_buf_pkg::*;
#(
  parameter int          H_RES     = H_RES_DEF,
  parameter int          V_RES     = V_RES_DEF,
  parameter logic [31:0] BASE_ADDR = 32'h0800_0000,
  localparam int         DEPTH     = H_RES * V_RES,
  localparam int         IDX_W     = $clog2(DEPTH)
) (
  input  logic             sys_clk_clk,
  input  logic             sys_reset_reset,
  input  logic [31:0]      pixel_slave_address,
  input  logic             pixel_slave_read,
  input  logic             pixel_slave_lock,
  output logic             pixel_slave_waitrequest,
  output logic [PIX_W-1:0] pixel_slave_readdata,
  output logic             pixel_slave_readdatavalid,
  input  logic [IDX_W-1:0] draw_address,
  input  logic             draw_write,
  input  logic [PIX_W-1:0] draw_writedata,
  output logic             draw_waitrequest,
  input  logic             clear_start,
  input  logic [PIX_W-1:0] clear_color,
  output logic             clear_busy,
  output logic             clear_done
);

  // Handshake: a read is taken on any edge with read=1 and waitrequest=0; its
  // readdatavalid comes two edges later. A draw is taken on draw_write=1 and
  // draw_waitrequest=0. Waitrequests never depend on the request inputs.

  logic [31:0]      offset;
  logic [30:0]      word_idx;
  logic             below_base;
  logic             rd_in_range;
  logic             rd_accept;
  logic [IDX_W-1:0] rd_idx;
  logic             draw_in_range;
  logic             draw_accept;

  logic             ram_we;
  logic [IDX_W-1:0] ram_waddr;
  logic [PIX_W-1:0] ram_wdata;
  logic [PIX_W-1:0] ram_q;

  logic             rd_v1;
  logic             rd_ok1;

  assign offset        = pixel_slave_address - BASE_ADDR;
  assign word_idx      = offset[31:1];
  assign below_base    = pixel_slave_address < BASE_ADDR;
  assign rd_in_range   = !below_base && (word_idx < 31'(DEPTH));
  assign rd_idx        = word_idx[IDX_W-1:0];
  assign rd_accept     = pixel_slave_read && !pixel_slave_waitrequest;
  assign draw_in_range = draw_address < IDX_W'(DEPTH);
  assign draw_accept   = draw_write && !draw_waitrequest && draw_in_range;

  pixel_buf_ram #(
    .DEPTH (DEPTH),
    .AW    (IDX_W),
    .DW    (PIX_W)
  ) u_ram (
    .clk   (sys_clk_clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (rd_accept && rd_in_range),
    .raddr (rd_idx),
    .rdata (ram_q)
  );

  // Stage 1 tracks the RAM access; stage 2 registers the response and
  // substitutes black for out-of-window addresses.
  always_ff @(posedge sys_clk_clk) begin
    if (sys_reset_reset) begin
      rd_v1                     <= 1'b0;
      rd_ok1                    <= 1'b0;
      pixel_slave_readdatavalid <= 1'b0;
      pixel_slave_readdata      <= PIX_BLACK;
    end else begin
      rd_v1                     <= rd_accept;
      rd_ok1                    <= rd_in_range;
      pixel_slave_readdatavalid <= rd_v1;
      if (rd_v1) pixel_slave_readdata <= rd_ok1 ? ram_q : PIX_BLACK;
    end
  end

`ifdef PIXEL_BUF_CLEAR_EN

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  clr_state_t       clr_state;
  clr_state_t       clr_next;
  logic [IDX_W-1:0] clr_cnt;
  logic [PIX_W-1:0] clr_color;
  logic             unused_sink;

  always_ff @(posedge sys_clk_clk) begin
    if (sys_reset_reset) begin
      clr_state  <= CLR_IDLE;
      clr_cnt    <= '0;
      clr_color  <= PIX_BLACK;
      clear_done <= 1'b0;
    end else begin
      clr_state  <= clr_next;
      clear_done <= (clr_state == CLR_RUN) && (clr_cnt == LAST_IDX);
      if (clr_state == CLR_IDLE && clear_start) begin
        clr_cnt   <= '0;
        clr_color <= clear_color;
      end else if (clr_state == CLR_RUN) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    clr_next = clr_state;
    case (clr_state)
      CLR_IDLE: if (clear_start) clr_next = CLR_RUN;
      CLR_RUN:  if (clr_cnt == LAST_IDX) clr_next = CLR_IDLE;
      default:  clr_next = CLR_IDLE;
    endcase
  end

  assign clear_busy              = (clr_state == CLR_RUN);
  assign pixel_slave_waitrequest = clear_busy;
  assign draw_waitrequest        = clear_busy;

  // The clear engine owns the write port while running; draws are stalled.
  assign ram_we    = clear_busy || draw_accept;
  assign ram_waddr = clear_busy ? clr_cnt : draw_address;
  assign ram_wdata = clear_busy ? clr_color : draw_writedata;

  assign unused_sink = ^{pixel_slave_lock, offset[0]};

`else

  logic unused_sink;

  assign clear_busy              = 1'b0;
  assign clear_done              = 1'b0;
  assign pixel_slave_waitrequest = 1'b0;
  assign draw_waitrequest        = 1'b0;

  assign ram_we    = draw_accept;
  assign ram_waddr = draw_address;
  assign ram_wdata = draw_writedata;

  assign unused_sink = ^{pixel_slave_lock, offset[0], clear_start, clear_color};

`endif

endmodule

// File: tb/tb_pixel_buffer_responder.sv
// Directed bench for pixel_buffer_responder; clear-engine tests run when
// PIXEL_BUF_CLEAR_EN is defined.
module tb_pixel_buffer_responder;

  localparam logic [31:0] BASE  = 32'h0800_0000;
  localparam int          DEPTH = 76800;
  localparam int          IDX_W = 17;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       pixel_slave_address = '0;
  logic              pixel_slave_read = 1'b0;
  logic              pixel_slave_lock = 1'b0;
  logic              pixel_slave_waitrequest;
  logic [15:0]       pixel_slave_readdata;
  logic              pixel_slave_readdatavalid;
  logic [IDX_W-1:0]  draw_address = '0;
  logic              draw_write = 1'b0;
  logic [15:0]       draw_writedata = '0;
  logic              draw_waitrequest;
  logic              clear_start = 1'b0;
  logic [15:0]       clear_color = '0;
  logic              clear_busy;
  logic              clear_done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  logic [15:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [15:0] last_exp = 16'h0000;

  pixel_buffer_responder dut (
    .sys_clk_clk               (clk),
    .sys_reset_reset           (rst),
    .pixel_slave_address       (pixel_slave_address),
    .pixel_slave_read          (pixel_slave_read),
    .pixel_slave_lock          (pixel_slave_lock),
    .pixel_slave_waitrequest   (pixel_slave_waitrequest),
    .pixel_slave_readdata      (pixel_slave_readdata),
    .pixel_slave_readdatavalid (pixel_slave_readdatavalid),
    .draw_address              (draw_address),
    .draw_write                (draw_write),
    .draw_writedata            (draw_writedata),
    .draw_waitrequest          (draw_waitrequest),
    .clear_start               (clear_start),
    .clear_color               (clear_color),
    .clear_busy                (clear_busy),
    .clear_done                (clear_done)
  );

  // Clock and cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every valid beat must match the oldest expected read, in order and on time.
  always @(negedge clk) begin
    if (clear_busy) busy_cnt++;
    if (clear_done) done_cnt++;
    if (pixel_slave_readdatavalid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        last_exp = exp_q.pop_front();
        check("rd_data", 32'(pixel_slave_readdata), 32'(last_exp));
        check("rd_latency", 32'(cyc), 32'(exp_cyc_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic draw(input int idx, input logic [15:0] data);
    int n;
    draw_address   = IDX_W'(idx);
    draw_writedata = data;
    draw_write     = 1'b1;
    n = 0;
    while (draw_waitrequest && n < 80000) begin
      tick();
      n++;
    end
    if (draw_waitrequest) check("draw_stall_timeout", 32'd1, 32'd0);
    tick();
    draw_write = 1'b0;
  endtask

  task automatic read_addr(input logic [31:0] addr, input logic [15:0] exp);
    int n;
    pixel_slave_address = addr;
    pixel_slave_read    = 1'b1;
    n = 0;
    while (pixel_slave_waitrequest && n < 80000) begin
      tick();
      n++;
    end
    if (pixel_slave_waitrequest) check("read_stall_timeout", 32'd1, 32'd0);
    exp_q.push_back(exp);
    exp_cyc_q.push_back(cyc + 2);
    tick();
    pixel_slave_read = 1'b0;
  endtask

  task automatic read_idx(input int idx, input logic [15:0] exp);
    read_addr(BASE + 32'(2 * idx), exp);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      tick();
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int r;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_valid", 32'(pixel_slave_readdatavalid), 32'd0);
    check("rst_rdata", 32'(pixel_slave_readdata), 32'h0);
    check("rst_wait_pix", 32'(pixel_slave_waitrequest), 32'd0);
    check("rst_wait_draw", 32'(draw_waitrequest), 32'd0);
    check("rst_busy", 32'(clear_busy), 32'd0);
    check("rst_done", 32'(clear_done), 32'd0);

    // Corner pixels
    draw(0, 16'hF800);
    draw(76799, 16'h07E0);
    read_addr(BASE, 16'hF800);
    read_addr(BASE + 32'd153598, 16'h07E0);
    read_addr(BASE + 32'd1, 16'hF800);
    drain();
    repeat (2) tick();
    check("rdata_hold", 32'(pixel_slave_readdata), 32'hF800);

    // Back-to-back stream
    for (int k = 0; k < 8; k++) draw(k, 16'(k * 16'h0101));
    for (int k = 0; k < 8; k++) read_idx(k, 16'(k * 16'h0101));
    drain();

    // Out-of-window reads return black
    read_addr(BASE + 32'd153600, 16'h0000);
    read_addr(BASE - 32'd2, 16'h0000);
    drain();

    // Dropped out-of-range draw must not disturb anything
    draw(76800, 16'hDEAD);
    read_idx(76799, 16'h07E0);
    drain();

    // Read-before-write collision
    draw(5, 16'h1234);
    pixel_slave_address = BASE + 32'd10;
    pixel_slave_read    = 1'b1;
    draw_address        = IDX_W'(5);
    draw_writedata      = 16'hAAAA;
    draw_write          = 1'b1;
    exp_q.push_back(16'h1234);
    exp_cyc_q.push_back(cyc + 2);
    tick();
    pixel_slave_read = 1'b0;
    draw_write       = 1'b0;
    read_idx(5, 16'hAAAA);
    drain();

`ifdef PIXEL_BUF_CLEAR_EN
    // Full clear with a stalled draw and an ignored restart
    busy_cnt    = 0;
    done_cnt    = 0;
    clear_color = 16'h001F;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    clear_color = 16'hFFFF;
    check("clr_busy_on", 32'(clear_busy), 32'd1);
    check("clr_wait_pix", 32'(pixel_slave_waitrequest), 32'd1);
    check("clr_wait_draw", 32'(draw_waitrequest), 32'd1);
    repeat (10) tick();
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    draw(300, 16'hBEEF);
    tick();
    check("clr_busy_cycles", 32'(busy_cnt), 32'd76800);
    check("clr_done_pulses", 32'(done_cnt), 32'd1);
    read_idx(300, 16'hBEEF);
    read_idx(0, 16'h001F);
    read_idx(76799, 16'h001F);
    for (int k = 0; k < 6; k++) begin
      r = $urandom_range(400, 76798);
      read_idx(r, 16'h001F);
    end
    drain();

    // Reset partway through a clear leaves a partial fill
    draw(0, 16'h0000);
    draw(50, 16'h0000);
    draw(98, 16'h0000);
    draw(200, 16'h4321);
    done_cnt    = 0;
    clear_color = 16'h001F;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (99) tick();
    rst = 1'b1;
    tick();
    check("abort_busy", 32'(clear_busy), 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    check("abort_no_done", 32'(done_cnt), 32'd0);
    read_idx(0, 16'h001F);
    read_idx(50, 16'h001F);
    read_idx(98, 16'h001F);
    read_idx(200, 16'h4321);
    drain();
`else
    // Clear inputs have no effect in this build
    clear_color = 16'h001F;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (3) tick();
    check("noclr_busy", 32'(clear_busy), 32'd0);
    check("noclr_done", 32'(done_cnt), 32'd0);
    check("noclr_wait_pix", 32'(pixel_slave_waitrequest), 32'd0);
    read_idx(1, 16'h0101);
    read_idx(76799, 16'h07E0);
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
